tiny_fetch: RTL and testbench

Instruction fetch stage for the TinyCPU core. It holds the program in a small synchronous-read instruction memory and walks a fetch PC through it. Fetched words are buffered in a 2-entry queue and handed to the downstream execute stage over a valid/ready handshake. Execute sends back branch redirects and a halt request. A separate write port loads the program from the testbench.

---
 rtl/tiny_cpu_pkg.sv | 22 ++
 rtl/tiny_fetch_fifo.sv | 68 ++++++
 rtl/tiny_fetch.sv | 102 ++++++++++
 tb/tb_tiny_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared TinyCPU types: instruction word layout, opcodes and the default
// instruction memory depth used by the fetch stage.
package tiny_cpu_pkg;

    localparam int unsigned INSTR_W       = 16;
    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_LDI  = 4'h1;
    localparam opcode_t OP_ADD  = 4'h2;
    localparam opcode_t OP_JMP  = 4'h3;
    localparam opcode_t OP_HALT = 4'hF;

    typedef struct packed {
        opcode_t    opcode;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } instr_t;

endpackage

// File: rtl/tiny_fetch_fifo.sv
// Two-entry shift FIFO: the head always sits in slot0 so the head outputs
// come straight from a register. Flush wins over push/pop.
module tiny_fetch_fifo #(
    parameter int unsigned W = 20
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = data_i;
                    else                 slot1_d = data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        slot0_d = data_i;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/tiny_fetch.sv
// TinyCPU fetch stage: synchronous-read program memory, fetch PC, one read in
// flight and a 2-entry output queue toward execute, with redirect and halt.
module tiny_fetch
    import tiny_cpu_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  instr_t        load_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          instr_valid,
    input  logic          instr_ready,
    output instr_t        instr,
    output logic [AW-1:0] instr_pc,
    output logic          fetch_idle
);

    localparam int unsigned EW = INSTR_W + AW;

    instr_t        mem_q [DEPTH];
    instr_t        rd_data_q;
    logic [AW-1:0] rd_pc_q;

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic          halted_q, halted_d;
    logic          fetch_idle_q, fetch_idle_d;

    logic          pop_c, push_c, issue_c;
    logic [2:0]    occ_c, cnt_next_c;
    logic [1:0]    fifo_count;
    logic          fifo_valid;
    logic [EW-1:0] fifo_head;

    // Issue/queue control and next-state for PC, in-flight and halt tracking.
    always_comb begin
        pop_c         = fifo_valid & instr_ready;
        push_c        = rd_inflight_q & ~redirect_valid;
        occ_c         = 3'(fifo_count) + 3'(rd_inflight_q) - 3'(pop_c);
        issue_c       = ~reset & ~halted_q & ~halt & ~redirect_valid & (occ_c < 3'd2);
        cnt_next_c    = redirect_valid ? 3'd0
                                       : 3'(fifo_count) + 3'(push_c) - 3'(pop_c);
        fetch_pc_d    = fetch_pc_q;
        if (redirect_valid)  fetch_pc_d = redirect_pc;
        else if (issue_c)    fetch_pc_d = fetch_pc_q + AW'(1);
        rd_inflight_d = issue_c;
        halted_d      = halted_q | halt;
        fetch_idle_d  = halted_d & (cnt_next_c == 3'd0) & ~rd_inflight_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            rd_inflight_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_idle_q  <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_inflight_q <= rd_inflight_d;
            halted_q      <= halted_d;
            fetch_idle_q  <= fetch_idle_d;
        end
    end

    // Program memory is never cleared; a same-cycle load and read of one address sees the old word.
    always_ff @(posedge clk) begin
        if (load_en) mem_q[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (issue_c) begin
            rd_data_q <= mem_q[fetch_pc_q];
            rd_pc_q   <= fetch_pc_q;
        end
    end

    tiny_fetch_fifo #(
        .W (EW)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (redirect_valid),
        .data_i  ({rd_data_q, rd_pc_q}),
        .valid_o (fifo_valid),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign instr_valid = fifo_valid;
    assign instr       = instr_t'(fifo_head[EW-1:AW]);
    assign instr_pc    = fifo_head[AW-1:0];
    assign fetch_idle  = fetch_idle_q;

endmodule

// File: tb/tb_tiny_fetch.sv
// Bench for tiny_fetch: directed scenarios plus a random ready/redirect run,
// checked against an in-order PC stream model over a mirror of program memory.
module tb_tiny_fetch;
    import tiny_cpu_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    instr_t        load_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic          instr_valid;
    logic          instr_ready;
    instr_t        instr;
    logic [AW-1:0] instr_pc;
    logic          fetch_idle;

    tiny_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_idle     (fetch_idle)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_deliv = 0;
    instr_t        mem_m [DEPTH];
    logic [AW-1:0] exp_pc = '0;
    logic          stall_prev = 1'b0;
    instr_t        hold_instr;
    logic [AW-1:0] hold_pc;
    logic [AW-1:0] seen_pc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score the current cycle against the stream model, then advance.
    task automatic cycle();
        if (reset) begin
            exp_pc     = '0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(instr_valid), 32'd1);
                chk("stall_instr", 32'(instr), 32'(hold_instr));
                chk("stall_pc", 32'(instr_pc), 32'(hold_pc));
            end
            if (instr_valid && instr_ready) begin
                chk("stream_pc", 32'(instr_pc), 32'(exp_pc));
                chk("stream_instr", 32'(instr), 32'(mem_m[exp_pc]));
                seen_pc.push_back(instr_pc);
                exp_pc = exp_pc + AW'(1);
                n_deliv++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            stall_prev = instr_valid && !instr_ready && !redirect_valid;
            hold_instr = instr;
            hold_pc    = instr_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input instr_t d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        mem_m[a]  = d;
        cycle();
        load_en   = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b1;
        halt  = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_pc(input logic [AW-1:0] target, input string tag);
        for (int i = 0; i < 40; i++) begin
            if (instr_valid && instr_pc == target) break;
            cycle();
        end
        chk(tag, 32'(instr_valid && instr_pc == target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b1;
        #1;
        // Program loads happen while reset is held.
        load(4'd0, instr_t'({OP_LDI, 12'h003}));
        load(4'd1, instr_t'({OP_LDI, 12'h105}));
        load(4'd2, instr_t'({OP_ADD, 12'h010}));
        load(4'd3, instr_t'({OP_HALT, 12'h000}));
        for (int a = 4; a < DEPTH; a++) load(AW'(a), instr_t'(16'($urandom)));
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", 32'(instr), 32'd0);
        chk("reset_pc", 32'(instr_pc), 32'd0);
        chk("reset_idle", 32'(fetch_idle), 32'd0);

        // Stream start-up: valid two edges after release, then one per cycle.
        reset = 1'b0; instr_ready = 1'b1;
        cycle();
        chk("startup_not_yet", 32'(instr_valid), 32'd0);
        cycle();
        chk("startup_valid", 32'(instr_valid), 32'd1);
        chk("startup_pc0", 32'(instr_pc), 32'd0);
        chk("startup_word0", 32'(instr), 32'h1003);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("throughput_valid", 32'(instr_valid), 32'd1);
        end

        // Backpressure: ready low for 5 cycles, then gap-free resumption.
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_resume_valid", 32'(instr_valid), 32'd1);
        end

        // Redirect to 9 while pc 4 is being accepted.
        restart();
        instr_ready = 1'b1;
        wait_pc(4'd4, "redir_reach_pc4");
        redirect_valid = 1'b1; redirect_pc = 4'd9;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_r1_empty", 32'(instr_valid), 32'd0);
        cycle();
        chk("redir_r2_empty", 32'(instr_valid), 32'd0);
        cycle();
        chk("redir_r3_valid", 32'(instr_valid), 32'd1);
        chk("redir_r3_pc9", 32'(instr_pc), 32'd9);
        cycle();
        chk("redir_next_pc10", 32'(instr_pc), 32'd10);

        // Halt while pc 2 is at the head: only pc 3 may still come out.
        restart();
        instr_ready = 1'b1;
        wait_pc(4'd2, "halt_reach_pc2");
        base = n_deliv;
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fetch_idle) break;
            cycle();
        end
        chk("halt_idle_rise", 32'(fetch_idle), 32'd1);
        chk("halt_drained_count", 32'(n_deliv - base), 32'd2);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("halt_idle_hold", 32'({fetch_idle, instr_valid}), 32'b10);
        end
        redirect_valid = 1'b1; redirect_pc = 4'd5;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("halt_redirect_stays", 32'({fetch_idle, instr_valid}), 32'b10);
        end

        // Wrap: redirect to 14 and expect 14, 15, 0, 1.
        restart();
        instr_ready = 1'b1;
        cycle();
        redirect_valid = 1'b1; redirect_pc = 4'd14;
        cycle();
        redirect_valid = 1'b0;
        seen_pc.delete();
        for (int i = 0; i < 10 && seen_pc.size() < 4; i++) cycle();
        chk("wrap_count", 32'(seen_pc.size()), 32'd4);
        if (seen_pc.size() >= 4) begin
            chk("wrap_pc14", 32'(seen_pc[0]), 32'd14);
            chk("wrap_pc15", 32'(seen_pc[1]), 32'd15);
            chk("wrap_pc0", 32'(seen_pc[2]), 32'd0);
            chk("wrap_pc1", 32'(seen_pc[3]), 32'd1);
        end

        // Reset mid-stream with the queue full.
        restart();
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("midreset_queued", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        cycle();
        chk("midreset_cleared", 32'(instr_valid), 32'd0);
        reset = 1'b0; instr_ready = 1'b1;
        cycle();
        cycle();
        chk("midreset_restart_valid", 32'(instr_valid), 32'd1);
        chk("midreset_restart_pc0", 32'(instr_pc), 32'd0);

        // Random ready and redirect traffic against the stream model.
        restart();
        base = n_deliv;
        for (int i = 0; i < 400; i++) begin
            instr_ready    = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(19) == 0);
            redirect_pc    = AW'($urandom);
            cycle();
        end
        redirect_valid = 1'b0;
        chk("random_progress", 32'(n_deliv - base > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
